add_result_fifo: RTL and testbench
==================================

ADD_RESULT_FIFO -- requirements
Module: add_result_fifo

Interface
REQ-001 SHALL provide parameter: DEPTH, 4, number of buffered result entries (power of two, 2..16).
REQ-002 SHALL provide parameter: CNT_W, 8, width of the overflow event counter.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: in_valid  input  1  upstream result valid.
REQ-007 Port: in_ready  output  1  buffer can accept an entry.
REQ-008 Port: sum  input  16  16-bit adder sum.
REQ-009 Port: cout, zero, parity, overflow  input  1 each  adder flags for the same result.
REQ-010 Port: out_valid  output  1  head entry valid.
REQ-011 Port: out_ready  input  1  downstream accepts head entry.
REQ-012 Port: out_sum  output  16  head entry sum.
REQ-013 Port: out_flags  output  4  head entry flags, packed {overflow, parity, zero, cout} as bits [3:0].
REQ-014 Port: level  output  log2(DEPTH)+1  current occupancy.
REQ-015 Port: sticky_flags  output  4  OR of all flags accepted since last clear, same packing as out_flags.
REQ-016 Port: clr_sticky  input  1  synchronous clear of sticky_flags and ovf_count.
REQ-017 Port: ovf_count  output  CNT_W  saturating count of accepted entries with overflow=1.

Function
REQ-018 Push SHALL occur on a rising edge where in_valid=1 and in_ready=1; the entry {sum, overflow, parity, zero, cout} is written at the tail.
REQ-019 Pop SHALL occur on a rising edge where out_valid=1 and out_ready=1; the head advances.
REQ-020 in_ready SHALL equal (level != DEPTH); out_valid SHALL equal (level != 0); both are purely registered-state-derived, with no combinational path from in_valid or out_ready.
REQ-021 Latency SHALL be one cycle: an entry pushed at edge N is visible on out_valid/out_sum/out_flags after edge N; there is no empty-buffer bypass.
REQ-022 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and preserve order.
REQ-023 When full, in_ready=0, so no push SHALL occur even if a pop happens the same cycle; when empty, out_ready is ignored.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by level, not by pointer equality alone.
REQ-025 out_sum/out_flags SHALL hold the head entry contents whenever out_valid=1 and SHALL be stable until popped.
REQ-026 sticky_flags SHALL update on each push as sticky_flags | entry_flags.
REQ-027 ovf_count SHALL increment by 1 on each push with overflow=1 and saturate at 2^CNT_W-1.
REQ-028 clr_sticky=1 SHALL zero sticky_flags and ovf_count; if a push occurs in the same cycle, the result SHALL be the pushed entry's flags and ovf_count = overflow (push wins after clear).

Reset
REQ-029 On rst=1, immediately and independent of clk: level=0, pointers=0, in_ready=1, out_valid=0, out_sum=0, out_flags=0, sticky_flags=0, ovf_count=0, storage cleared to 0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered entries; no partial push or pop survives.

Structure
REQ-031 A shared package SHALL hold the flag bit indices (COUT=0, ZERO=1, PARITY=2, OVF=3), the flag width 4, and the entry width 20.
REQ-032 Storage and pointer logic SHALL be one sub-module, res_fifo (width/depth parameterised); sticky and counter logic SHALL stay in add_result_fifo.

Verification
REQ-033 Push sum=16'h7FFF flags=4'b1000, then pop -> out_valid high one cycle after the push, out_sum=7FFF, out_flags=1000, ovf_count=1, sticky_flags=1000.
REQ-034 With out_ready=0, push 5 entries (sums 1..5) with in_valid held -> after 4 pushes in_ready=0, level=4; the 5th is accepted only after one pop; the pop order is 1,2,3,4,5.
REQ-035 With level=2, push and pop the same cycle -> level stays 2 and the order is preserved; with level=4, in_valid=1 and out_ready=1 -> pop only, level=3.
REQ-036 Push 300 entries with overflow=1 (CNT_W=8) -> ovf_count saturates at 255; clr_sticky together with a push of flags=4'b0011 -> sticky_flags=0011, ovf_count=0.
REQ-037 Assert rst asynchronously mid-cycle with level=3 -> outputs zero immediately, in_ready=1, out_valid=0; the first post-reset push is popped correctly.

Source files
------------

// File: rtl/add_result_fifo_pkg.sv
// -----------------------------------------------------------------------------
// add_result_fifo_pkg
// Shared definitions for the adder result buffer: flag bit positions inside
// the packed 4-bit flag field, field widths, and the stored entry layout.
// -----------------------------------------------------------------------------
package add_result_fifo_pkg;

  localparam int SUM_W   = 16;
  localparam int FLAG_W  = 4;
  localparam int ENTRY_W = SUM_W + FLAG_W;  // 20

  // Bit positions inside the packed flag field {overflow, parity, zero, cout}.
  localparam int FLAG_COUT   = 0;
  localparam int FLAG_ZERO   = 1;
  localparam int FLAG_PARITY = 2;
  localparam int FLAG_OVF    = 3;

  // One buffered result; sum occupies the upper bits of the stored word.
  typedef struct packed {
    logic [SUM_W-1:0]  sum;
    logic [FLAG_W-1:0] flags;
  } entry_t;

  // Pack the four adder flags into the shared flag layout.
  function automatic logic [FLAG_W-1:0] pack_flags(input logic cout,
                                                   input logic zero,
                                                   input logic parity,
                                                   input logic overflow);
    logic [FLAG_W-1:0] f;
    f              = '0;
    f[FLAG_COUT]   = cout;
    f[FLAG_ZERO]   = zero;
    f[FLAG_PARITY] = parity;
    f[FLAG_OVF]    = overflow;
    return f;
  endfunction

endpackage

// File: rtl/add_result_fifo_if.sv
// -----------------------------------------------------------------------------
// add_result_fifo_if
// Bundles the upstream push side, downstream pop side and status/sticky
// signals of add_result_fifo.
//   master : the environment (drives in_valid/sum/flags, out_ready, clr_sticky)
//   slave  : the buffer (drives in_ready, out_*, level, sticky_flags, ovf_count)
// -----------------------------------------------------------------------------
interface add_result_fifo_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) ();
  import add_result_fifo_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  // Push side
  logic              in_valid;
  logic              in_ready;
  logic [SUM_W-1:0]  sum;
  logic              cout;
  logic              zero;
  logic              parity;
  logic              overflow;
  // Pop side
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [FLAG_W-1:0] out_flags;
  // Status
  logic [LVL_W-1:0]  level;
  logic [FLAG_W-1:0] sticky_flags;
  logic              clr_sticky;
  logic [CNT_W-1:0]  ovf_count;

  modport master (
    output in_valid, sum, cout, zero, parity, overflow, out_ready, clr_sticky,
    input  in_ready, out_valid, out_sum, out_flags, level, sticky_flags, ovf_count
  );

  modport slave (
    input  in_valid, sum, cout, zero, parity, overflow, out_ready, clr_sticky,
    output in_ready, out_valid, out_sum, out_flags, level, sticky_flags, ovf_count
  );

endinterface

// File: rtl/add_result_fifo_res_fifo.sv
// -----------------------------------------------------------------------------
// res_fifo
// Width/depth parameterised storage with write/read pointers and an occupancy
// counter. Full/empty come from the level counter, so equal pointers are
// never ambiguous. The head word is read straight from registered storage,
// giving one cycle from push to visibility and no empty bypass.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_wr_valid     write request      o_wr_ready  level != DEPTH
//   i_wr_data      word to store
//   o_rd_valid     level != 0         i_rd_ready  consumer takes head
//   o_rd_data      head word          o_level     current occupancy
// -----------------------------------------------------------------------------
module res_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [W-1:0]     i_wr_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [W-1:0]     o_rd_data,
  output logic [LVL_W-1:0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_push;
  logic w_pop;

  // Handshake qualifiers depend only on registered level.
  assign o_wr_ready = (r_level != LVL_W'(DEPTH));
  assign o_rd_valid = (r_level != '0);
  assign w_push     = i_wr_valid && o_wr_ready;
  assign w_pop      = i_rd_ready && o_rd_valid;

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_level    = r_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        // DEPTH is a power of two, so natural overflow is the modulo wrap.
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/add_result_fifo.sv
// -----------------------------------------------------------------------------
// add_result_fifo
// Buffers adder results {sum, flags} in a small FIFO and keeps running
// statistics over every accepted entry: an OR-accumulated sticky flag field
// and a saturating count of entries that carried overflow.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus (slave)  push side (in_valid/in_ready/sum/flags), pop side
//                (out_valid/out_ready/out_sum/out_flags), level,
//                sticky_flags, clr_sticky, ovf_count
// -----------------------------------------------------------------------------
module add_result_fifo
  import add_result_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  add_result_fifo_if.slave  bus
);

  localparam int               LVL_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t            w_wr_entry;
  entry_t            w_rd_entry;
  logic              w_push;
  logic [FLAG_W-1:0] w_in_flags;

  logic [FLAG_W-1:0] r_sticky;
  logic [CNT_W-1:0]  r_ovf_cnt;

  assign w_in_flags       = pack_flags(bus.cout, bus.zero, bus.parity, bus.overflow);
  assign w_wr_entry.sum   = bus.sum;
  assign w_wr_entry.flags = w_in_flags;

  res_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_res_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (bus.in_valid),
    .o_wr_ready (bus.in_ready),
    .i_wr_data  (w_wr_entry),
    .o_rd_valid (bus.out_valid),
    .i_rd_ready (bus.out_ready),
    .o_rd_data  (w_rd_entry),
    .o_level    (bus.level)
  );

  assign bus.out_sum   = w_rd_entry.sum;
  assign bus.out_flags = w_rd_entry.flags;

  // Same qualification the storage uses for its own write.
  assign w_push = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky  <= '0;
      r_ovf_cnt <= '0;
    end else if (bus.clr_sticky) begin
      // Clear first, then a same-cycle push lands on the cleared state.
      r_sticky  <= w_push ? w_in_flags : '0;
      r_ovf_cnt <= (w_push && w_in_flags[FLAG_OVF]) ? CNT_W'(1) : '0;
    end else if (w_push) begin
      r_sticky <= r_sticky | w_in_flags;
      if (w_in_flags[FLAG_OVF] && (r_ovf_cnt != CNT_MAX)) begin
        r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.sticky_flags = r_sticky;
  assign bus.ovf_count    = r_ovf_cnt;

endmodule

// File: tb/tb_add_result_fifo.sv
module tb_add_result_fifo;
  import add_result_fifo_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of {sum, flags}, sticky OR, overflow count.
  logic [19:0] q[$];
  logic [3:0]  m_sticky = 4'h0;
  int          m_cnt    = 0;

  add_result_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  add_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string ctx);
    chk({ctx, ":out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    chk({ctx, ":in_ready"},  32'(bus.in_ready),  32'(q.size() != DEPTH));
    chk({ctx, ":level"},     32'(bus.level),     32'(q.size()));
    if (q.size() != 0) begin
      chk({ctx, ":out_sum"},   32'(bus.out_sum),   32'(q[0][19:4]));
      chk({ctx, ":out_flags"}, 32'(bus.out_flags), 32'(q[0][3:0]));
    end
    chk({ctx, ":sticky"}, 32'(bus.sticky_flags), 32'(m_sticky));
    chk({ctx, ":ovf_cnt"}, 32'(bus.ovf_count),   32'(m_cnt));
  endtask

  task automatic check_reset_outputs(input string ctx);
    chk({ctx, ":level"},     32'(bus.level),        32'd0);
    chk({ctx, ":in_ready"},  32'(bus.in_ready),     32'd1);
    chk({ctx, ":out_valid"}, 32'(bus.out_valid),    32'd0);
    chk({ctx, ":out_sum"},   32'(bus.out_sum),      32'd0);
    chk({ctx, ":out_flags"}, 32'(bus.out_flags),    32'd0);
    chk({ctx, ":sticky"},    32'(bus.sticky_flags), 32'd0);
    chk({ctx, ":ovf_cnt"},   32'(bus.ovf_count),    32'd0);
  endtask

  // Called at a negedge: check current state, drive inputs, clock once,
  // advance the model, return at the next negedge.
  task automatic cycle(input string ctx, input bit inv, input logic [15:0] s,
                       input logic [3:0] f, input bit outr, input bit clr);
    bit do_push;
    bit do_pop;
    check_state(ctx);
    bus.in_valid   = inv;
    bus.sum        = s;
    bus.cout       = f[0];
    bus.zero       = f[1];
    bus.parity     = f[2];
    bus.overflow   = f[3];
    bus.out_ready  = outr;
    bus.clr_sticky = clr;
    do_push = inv && (q.size() < DEPTH);
    do_pop  = outr && (q.size() > 0);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back({s, f});
    if (clr) begin
      m_sticky = do_push ? f : 4'h0;
      m_cnt    = (do_push && f[3]) ? 1 : 0;
    end else if (do_push) begin
      m_sticky = m_sticky | f;
      if (f[3] && m_cnt < CNT_MAX) m_cnt++;
    end
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.clr_sticky = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.sum        = '0;
    bus.cout       = 1'b0;
    bus.zero       = 1'b0;
    bus.parity     = 1'b0;
    bus.overflow   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.clr_sticky = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("step reset released");

    // Single overflow entry: visible one cycle after push, then popped
    cycle("ovf_push", 1, 16'h7FFF, 4'b1000, 0, 0);
    chk("ovf_push:visible", 32'(bus.out_valid), 32'd1);
    chk("ovf_push:sum", 32'(bus.out_sum), 32'h7FFF);
    chk("ovf_push:flags", 32'(bus.out_flags), 32'b1000);
    cycle("ovf_pop", 0, 16'h0, 4'h0, 1, 0);
    $display("step single overflow entry done");

    // Fill with out_ready low; fifth held entry waits for one pop
    for (int i = 1; i <= 4; i++) cycle("fill", 1, 16'(i), 4'h0, 0, 0);
    chk("full:level", 32'(bus.level), 32'd4);
    chk("full:in_ready", 32'(bus.in_ready), 32'd0);
    cycle("full_hold", 1, 16'd5, 4'h0, 0, 0);
    cycle("full_pop", 1, 16'd5, 4'h0, 1, 0);
    chk("full_pop:level", 32'(bus.level), 32'd3);
    cycle("fifth_push", 1, 16'd5, 4'h0, 0, 0);
    for (int i = 2; i <= 5; i++) begin
      chk("drain:order", 32'(bus.out_sum), 32'(i));
      cycle("drain", 0, 16'h0, 4'h0, 1, 0);
    end
    $display("step fill/drain order done");

    // Level 2: simultaneous push/pop keeps level
    cycle("l2_a", 1, 16'hA001, 4'b0001, 0, 0);
    cycle("l2_b", 1, 16'hA002, 4'b0010, 0, 0);
    cycle("l2_pp", 1, 16'hA003, 4'b0100, 1, 0);
    chk("l2_pp:level", 32'(bus.level), 32'd2);
    chk("l2_pp:head", 32'(bus.out_sum), 32'hA002);
    cycle("l2_c", 1, 16'hA004, 4'b0000, 0, 0);
    cycle("l2_d", 1, 16'hA005, 4'b0000, 0, 0);
    cycle("full_pp", 1, 16'hA006, 4'b0000, 1, 0);
    chk("full_pp:level", 32'(bus.level), 32'd3);
    for (int i = 0; i < 3; i++) cycle("l2_drain", 0, 16'h0, 4'h0, 1, 0);
    $display("step simultaneous push/pop done");

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      bit inv;
      bit outr;
      bit clr;
      inv  = ($urandom_range(0, 3) != 0);
      outr = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      cycle("rand", inv, 16'($urandom), 4'($urandom), outr, clr);
    end
    for (int i = 0; i < DEPTH; i++) cycle("rand_drain", 0, 16'h0, 4'h0, 1, 0);
    $display("step random traffic done");

    // Overflow counter saturation, then clear with same-cycle push
    cycle("sat_clr", 0, 16'h0, 4'h0, 0, 1);
    for (int i = 0; i < 300; i++) cycle("sat", 1, 16'(i), 4'b1000, 1, 0);
    chk("sat:ovf_count", 32'(bus.ovf_count), 32'd255);
    cycle("clr_push", 1, 16'h1234, 4'b0011, 1, 1);
    chk("clr_push:sticky", 32'(bus.sticky_flags), 32'b0011);
    chk("clr_push:ovf_count", 32'(bus.ovf_count), 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle("sat_drain", 0, 16'h0, 4'h0, 1, 0);
    $display("step saturation and clear done");

    // Asynchronous reset mid-cycle with level 3
    cycle("pre_rst", 1, 16'hB001, 4'b1111, 0, 0);
    cycle("pre_rst", 1, 16'hB002, 4'b1000, 0, 0);
    cycle("pre_rst", 1, 16'hB003, 4'b0100, 0, 0);
    cycle("pre_rst_idle", 0, 16'h0, 4'h0, 0, 0);
    chk("pre_rst:level", 32'(bus.level), 32'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    q.delete();
    m_sticky = 4'h0;
    m_cnt    = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst_push", 1, 16'hC0DE, 4'b0101, 0, 0);
    chk("post_rst:sum", 32'(bus.out_sum), 32'hC0DE);
    cycle("post_rst_pop", 0, 16'h0, 4'h0, 1, 0);
    check_state("post_rst_end");
    $display("step async reset done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
